// File: rtl/seg_display_arbiter_if.sv
// Bundle of the request/data inputs and display/grant outputs shared between
// the user logic (master) and the display arbiter (slave).
interface seg_display_arbiter_if;
  logic [3:0]  req;
  logic [15:0] data;
  logic [3:0]  gnt;
  logic [1:0]  active;
  logic        busy;
  logic        done;
  logic [6:0]  segments;

  modport master (
    output req,
    output data,
    input  gnt,
    input  active,
    input  busy,
    input  done,
    input  segments
  );

  modport slave (
    input  req,
    input  data,
    output gnt,
    output active,
    output busy,
    output done,
    output segments
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the single 7-segment display: grants one of four
// requesters, latches its hex-decoded nibble and holds it for HOLD_CYCLES.
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_display_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // Counter reload: the grant cycle itself is the first of the busy cycles.
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 32'd1);

  // Hex font, bit order {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Returns {found, index} of the first set request searching from ptr
  // upward (mod 4). Scanning backwards lets the nearest candidate win last.
  function automatic logic [2:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  active_q, active_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [6:0]  seg_q, seg_d;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [3:0]  win_nibble;

  // Winner search and selection of the winner's data nibble.
  always_comb begin
    {win_found, win_idx} = pick_winner(bus.req, ptr_q);
    case (win_idx)
      2'd0:    win_nibble = bus.data[3:0];
      2'd1:    win_nibble = bus.data[7:4];
      2'd2:    win_nibble = bus.data[11:8];
      2'd3:    win_nibble = bus.data[15:12];
      default: win_nibble = bus.data[3:0];
    endcase
  end

  // State register and all registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      cnt_q    <= 16'd0;
      gnt_q    <= 4'd0;
      active_q <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      seg_q    <= 7'h00;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      seg_q    <= seg_d;
    end
  end

  // Next-state logic: state, round-robin pointer and dwell counter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_SHOW;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          state_d = ST_IDLE;
          ptr_d   = active_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = 2'd0;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Output logic: grant pulse, owner index, busy/done flags and display.
  always_comb begin
    gnt_d    = 4'b0000;
    active_d = active_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    seg_d    = seg_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_d    = 4'b0001 << win_idx;
          active_d = win_idx;
          busy_d   = 1'b1;
          seg_d    = hex_font(win_nibble);
        end else begin
          busy_d   = 1'b0;
        end
      end
      ST_SHOW: begin
        if (cnt_q != 16'd0) begin
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.active   = active_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.segments = seg_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_seg_display_arbiter;

  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  seg_display_arbiter_if bus_if();

  seg_display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: owner, busy cycles still to show, next search start.
  bit         m_show;
  int         m_left;
  int         m_ptr;
  int         m_active;
  logic [3:0] m_gnt;
  logic       m_busy;
  logic       m_done;
  logic [6:0] m_seg;

  function automatic logic [14:0] obs();
    return {bus_if.gnt, bus_if.active, bus_if.busy, bus_if.done, bus_if.segments};
  endfunction

  function automatic logic [14:0] model_vec();
    return {m_gnt, 2'(m_active), m_busy, m_done, m_seg};
  endfunction

  task automatic model_update();
    int w;
    int nib;
    if (!rst_n) begin
      m_show = 0; m_left = 0; m_ptr = 0; m_active = 0;
      m_gnt = 4'd0; m_busy = 1'b0; m_done = 1'b0; m_seg = 7'h00;
    end else if (m_show) begin
      m_gnt  = 4'd0;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_show = 0; m_busy = 1'b0; m_done = 1'b1;
        m_ptr  = (m_active + 1) % 4;
      end else begin
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      m_gnt  = 4'd0;
      if (bus_if.req != 4'd0) begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          if (w < 0 && bus_if.req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        nib      = int'((bus_if.data >> (4 * w)) & 16'hF);
        m_gnt    = 4'(1 << w);
        m_active = w;
        m_busy   = 1'b1;
        m_seg    = font_tab[nib];
        m_left   = HOLD;
        m_show   = 1;
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_grant(input int limit, output bit got);
    got = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (bus_if.gnt != 4'd0) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.req  = 4'hF;
    bus_if.data = 16'($urandom);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs() !== 15'd0) begin
        errors++;
        $display("FAIL reset: outputs=%h required=%h", obs(), 15'd0);
      end
    end
  endtask

  task automatic test_single();
    int n;
    bit saw_gnt;
    bit seg_bad;
    rst_n = 1'b1;
    bus_if.req  = 4'b0001;
    bus_if.data = 16'h0005;
    step();
    checks++;
    if (obs() !== {4'b0001, 2'd0, 1'b1, 1'b0, 7'h6D}) begin
      errors++;
      $display("FAIL single_grant: outputs=%h required=%h", obs(), {4'b0001, 2'd0, 1'b1, 1'b0, 7'h6D});
    end
    bus_if.req = 4'b0000;
    n = 1; saw_gnt = 0; seg_bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_if.gnt != 4'd0) saw_gnt = 1;
      if (bus_if.segments !== 7'h6D) seg_bad = 1;
      if (bus_if.busy) n++;
      else break;
    end
    checks++;
    if (n != HOLD || !bus_if.done || saw_gnt || seg_bad) begin
      errors++;
      $display("FAIL single_dwell: busy=%0d done=%b extra_gnt=%b seg_bad=%b required busy=%0d done=1 extra_gnt=0 seg_bad=0",
               n, bus_if.done, saw_gnt, seg_bad, HOLD);
    end
    step();
    step();
    checks++;
    if (bus_if.segments !== 7'h6D || bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: seg=%h done=%b busy=%b required seg=6d done=0 busy=0",
               bus_if.segments, bus_if.done, bus_if.busy);
    end
  endtask

  task automatic test_rotation();
    logic [6:0] exp_seg [5] = '{7'h39, 7'h5E, 7'h79, 7'h71, 7'h39};
    int exp_act [5] = '{0, 1, 2, 3, 0};
    int g_cyc [5];
    int g_act [5];
    logic [6:0] g_seg [5];
    int ng;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus_if.req  = 4'hF;
    bus_if.data = 16'hFEDC;
    ng = 0;
    for (int i = 0; i < 200 && ng < 5; i++) begin
      step();
      if (bus_if.gnt != 4'd0) begin
        g_cyc[ng] = cyc;
        g_act[ng] = int'(bus_if.active);
        g_seg[ng] = bus_if.segments;
        ng++;
      end
    end
    checks++;
    if (ng != 5) begin
      errors++;
      $display("FAIL rotation_count: grants=%0d required=5", ng);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (g_act[k] != exp_act[k] || g_seg[k] !== exp_seg[k] ||
            (k > 0 && g_cyc[k] - g_cyc[k-1] != HOLD + 1)) begin
          errors++;
          $display("FAIL rotation_%0d: owner=%0d seg=%h gap=%0d required owner=%0d seg=%h gap=%0d",
                   k, g_act[k], g_seg[k], (k > 0) ? g_cyc[k] - g_cyc[k-1] : 0,
                   exp_act[k], exp_seg[k], (k > 0) ? HOLD + 1 : 0);
        end
      end
    end
  endtask

  task automatic test_pointer_wrap();
    bit got;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus_if.req  = 4'b0100;
    bus_if.data = 16'h0C0A;
    wait_grant(10, got);
    checks++;
    if (!got || bus_if.active !== 2'd2 || bus_if.segments !== 7'h39) begin
      errors++;
      $display("FAIL wrap_first: got=%b active=%0d seg=%h required got=1 active=2 seg=39",
               got, bus_if.active, bus_if.segments);
    end
    bus_if.req = 4'b0101;
    wait_grant(40, got);
    checks++;
    if (!got || bus_if.gnt !== 4'b0001 || bus_if.active !== 2'd0 || bus_if.segments !== 7'h77) begin
      errors++;
      $display("FAIL wrap_second: got=%b gnt=%b active=%0d seg=%h required got=1 gnt=0001 active=0 seg=77",
               got, bus_if.gnt, bus_if.active, bus_if.segments);
    end
  endtask

  task automatic test_mid_dwell();
    int n;
    bit seg_bad;
    bus_if.req  = 4'b0000;
    bus_if.data = 16'hFFFF;
    n = 1; seg_bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_if.segments !== 7'h77) seg_bad = 1;
      if (bus_if.busy) n++;
      else break;
    end
    checks++;
    if (n != HOLD || !bus_if.done || seg_bad || bus_if.segments !== 7'h77) begin
      errors++;
      $display("FAIL mid_dwell: busy=%0d done=%b seg=%h seg_bad=%b required busy=%0d done=1 seg=77 seg_bad=0",
               n, bus_if.done, bus_if.segments, seg_bad, HOLD);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    bit saw_done;
    bus_if.req  = 4'b0010;
    bus_if.data = 16'h0020;
    wait_grant(10, got);
    checks++;
    if (!got || bus_if.active !== 2'd1 || bus_if.segments !== 7'h5B) begin
      errors++;
      $display("FAIL rmid_grant: got=%b active=%0d seg=%h required got=1 active=1 seg=5b",
               got, bus_if.active, bus_if.segments);
    end
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus_if.done) saw_done = 1;
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (obs() !== 15'd0 || saw_done) begin
      errors++;
      $display("FAIL rmid_reset: outputs=%h early_done=%b required outputs=0 early_done=0", obs(), saw_done);
    end
    rst_n = 1'b1;
    bus_if.req  = 4'hF;
    bus_if.data = 16'h0008;
    step();
    checks++;
    if (obs() !== {4'b0001, 2'd0, 1'b1, 1'b0, 7'h7F}) begin
      errors++;
      $display("FAIL rmid_regrant: outputs=%h required=%h", obs(), {4'b0001, 2'd0, 1'b1, 1'b0, 7'h7F});
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 1500; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      bus_if.req  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      bus_if.data = 16'($urandom);
      step();
      checks++;
      if (obs() !== model_vec() || (bus_if.gnt != 4'd0 && bus_if.done)) begin
        errors++;
        bad++;
        if (bad <= 10) begin
          $display("FAIL random cyc=%0d: outputs=%h required=%h", cyc, obs(), model_vec());
        end
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus_if.req  = 4'd0;
    bus_if.data = 16'd0;
    test_reset();
    test_single();
    test_rotation();
    test_pointer_wrap();
    test_mid_dwell();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Round-robin scheduler that shares the project's single 7-segment display between four requesters. Each granted requester's 4-bit value is captured, hex-decoded and held on the segment outputs for a fixed dwell time. The block sits between the user logic and `uo_out[6:0]` inside the top-level `tt_um_` wrapper.

## Interface
Parameters:
- `HOLD_CYCLES`, default 16: dwell time per grant, in clock cycles. Legal range is 2..65535. The counter is 16 bits.

Ports:
- `clk` in 1: the single clock. All logic is rising-edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req` in 4: `req[i]` high means requester i wants the display. It is level-sensitive and sampled only in IDLE.
- `data` in 16: `data[4i+3:4i]` is requester i's value. It is sampled only on the grant edge.
- `gnt` out 4: one-hot grant, high for exactly one cycle.
- `active` out 2: index of the current or most recent owner.
- `busy` out 1: high while in SHOW.
- `done` out 1: one-cycle pulse when a dwell ends.
- `segments` out 7: bit order {g,f,e,d,c,b,a}, active high.

## Operation
- There are two states: IDLE and SHOW. All outputs are registered.
- Reset values: state IDLE, `gnt`=0, `active`=0, `busy`=0, `done`=0, `segments`=7'h00 (blank), round-robin pointer `ptr`=0, dwell counter `cnt`=0.
- **IDLE with `req`==0:** remain in IDLE. `gnt`=0 and `done`=0. `segments` keeps its last value.
- **IDLE with `req`!=0:**
  - Select the winner w as the first set bit of `req` in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the same edge: `gnt`=1<<w, `active`=w, `busy`=1, `cnt`=HOLD_CYCLES-1, `segments`=font(data nibble w), next state SHOW.
- **SHOW with `cnt`!=0:** `cnt` decrements. `gnt` returns to 0 on the first SHOW cycle.
- **SHOW with `cnt`==0:** `done`=1, `busy`=0, `ptr`=w+1 (mod 4), next state IDLE.
- In SHOW, `req` and `data` are ignored. Dropping a request or changing data mid-dwell does not affect the display.
- Font (value -> segments hex):
  - 0->3F, 1->06, 2->5B, 3->4F, 4->66, 5->6D, 6->7D, 7->07
  - 8->7F, 9->6F, A->77, b->7C, C->39, d->5E, E->79, F->71
- `segments` changes only on a grant edge or on reset.

## Timing
- **Grant latency:** `req` high before edge E0 while in IDLE gives `gnt`, `busy` and new `segments` visible after E0.
- **Dwell length:** `busy` is high for exactly HOLD_CYCLES cycles.
- **End of dwell:** `done` pulses in the cycle after the last busy cycle, and the state is IDLE in that cycle.
- **Grant spacing:** the minimum spacing between grant edges is HOLD_CYCLES+1 cycles. This arises because one IDLE cycle, the cycle in which `done` is high, is always inserted between dwells.
- **Simultaneous events:** `gnt` and `done` are never high in the same cycle.
- **Fairness:** with all requests held, grants rotate 0,1,2,3,0,…
- **Reset mid-SHOW:** reset while in SHOW forces all reset values on that edge. The display blanks, `ptr` returns to 0 and the dwell is abandoned with no `done` pulse.
- **Reset priority:** `rst_n` low has priority over every other condition.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `req`=4'hF. Required: `segments`=00, `gnt`=0, `busy`=0, `done`=0, `active`=0 throughout.
- **Single request:** `req`=0001, `data`=16'h0005. Required: `gnt`=0001 for 1 cycle; `segments`=6D; `busy` high for 16 cycles; then `done` for 1 cycle; `segments` stays 6D after the dwell.
- **Rotation:** `req`=1111, `data`=16'hFEDC. Required:
  - Grants in order 0,1,2,3,0, with grant edges 17 cycles apart.
  - `segments` sequence 39,5E,79,71,39.
- **Pointer wrap:** after a grant to requester 2, drive `req`=0101. Required: next `gnt`=0001 (search order 3,0,…), `active`=0.
- **Mid-dwell changes:** during SHOW, drop `req` to 0 and change `data` to 16'hFFFF. Required: `segments` unchanged for the full dwell and `done` pulses on schedule.
- **Reset mid-dwell:** assert `rst_n`=0 on the 5th SHOW cycle, then release with `req`=1111, `data`=16'h0008. Required:
  - No `done` pulse; `segments`=00 after the reset edge.
  - The next grant goes to requester 0, with `segments`=7F.
